// File: rtl/eth_10g_mac_st_timing_adapter_rl_pkg.sv
// Shared definitions for the 10G MAC Avalon-ST adapters: occupancy width helper,
// ready-latency limit and the DEPTH/IN_RL legality check used at elaboration.
`ifndef ETH_10G_ST_PKG_SV
`define ETH_10G_ST_PKG_SV

`define ETH_10G_ST_CHECK_RL_DEPTH(depth, rl) \
    if ((rl) < 0 || (rl) > eth_10g_st_pkg::MAX_IN_RL) begin : g_bad_in_rl \
        $error("eth_10g_st: IN_RL=%0d outside 0..%0d", (rl), eth_10g_st_pkg::MAX_IN_RL); \
    end \
    if ((depth) < (rl) + 1 || (depth) > eth_10g_st_pkg::MAX_DEPTH || ((depth) & ((depth) - 1)) != 0) begin : g_bad_depth \
        $error("eth_10g_st: DEPTH=%0d must be a power of two in IN_RL+1..%0d", (depth), eth_10g_st_pkg::MAX_DEPTH); \
    end

package eth_10g_st_pkg;

    localparam int MAX_IN_RL = 3;
    localparam int MAX_DEPTH = 256;

    // Bits needed to hold the values 0..n inclusive (an occupancy count).
    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`endif

// File: rtl/eth_10g_mac_st_timing_adapter_rl_if.sv
// Avalon-ST sink (ready-latency IN_RL) and source (ready-latency 0) handshake bundle.
interface eth_10g_mac_st_timing_adapter_rl_if #(
    parameter int DATA_W = 16
);
    logic              in_ready;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport slave (
        output in_ready,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        input  in_ready,
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/eth_10g_mac_st_timing_adapter_rl_fifo_ram.sv
// DEPTH x DATA_W storage: registered write, asynchronous read (maps to MLAB or flops).
module eth_10g_st_fifo_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/eth_10g_mac_st_timing_adapter_rl.sv
// Avalon-ST timing adapter: ready-latency IN_RL sink to ready-latency 0 source through a
// DEPTH-entry FIFO, with fill level and a sticky overflow flag for dropped beats.
module eth_10g_mac_st_timing_adapter_rl
    import eth_10g_st_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IN_RL  = 0,
    parameter int DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    eth_10g_mac_st_timing_adapter_rl_if.slave st,
    output logic [clog2_p1(DEPTH)-1:0]        fill_level,
    output logic                              overflow,
    input  logic                              clr_ovf
);
    `ETH_10G_ST_CHECK_RL_DEPTH(DEPTH, IN_RL)

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = clog2_p1(DEPTH);
    localparam logic [MAX_IN_RL-1:0] GNT_MASK = MAX_IN_RL'((1 << IN_RL) - 1);

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [MAX_IN_RL-1:0] gnt_sr;
    logic [1:0]           pending;
    logic [1:0]           ign_cnt;
    logic                 rdy_en;
    logic                 accept;
    logic                 room;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic [DATA_W-1:0]    rd_data;

    function automatic logic [1:0] grant_popcount(input logic [MAX_IN_RL-1:0] v);
        logic [1:0] n;
        n = '0;
        for (int i = 0; i < MAX_IN_RL; i++) begin
            n = n + 2'(v[i]);
        end
        return n;
    endfunction

    // Explicit wrap keeps DEPTH=1 (single-entry, 1-bit pointer) correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Grants still in flight reserve space, so a compliant source can never overflow.
    assign pending     = grant_popcount(gnt_sr & GNT_MASK);
    assign st.in_ready = rdy_en && ((32'(count) + 32'(pending)) < DEPTH);

    assign st.out_valid = (count != '0);
    assign st.out_data  = st.out_valid ? rd_data : '0;
    assign fill_level   = count;

    // Beats landing in the IN_RL cycles after reset belong to no grant and are ignored.
    assign accept = st.in_valid && (ign_cnt == 2'd0);
    assign pop    = st.out_valid && st.out_ready;
    assign room   = (32'(count) < DEPTH) || pop;
    assign push   = accept && room;
    assign drop   = accept && !room;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            gnt_sr   <= '0;
            rdy_en   <= 1'b0;
            ign_cnt  <= 2'(IN_RL);
            overflow <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            gnt_sr <= {gnt_sr[MAX_IN_RL-2:0], st.in_ready};
            if (ign_cnt != 2'd0) begin
                ign_cnt <= ign_cnt - 1'b1;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    eth_10g_st_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (st.in_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_eth_10g_mac_st_timing_adapter_rl.sv
// Scoreboard bench: directed stimulus on RL2/D8 and RL2/D4 instances, random out_ready
// on RL0/RL1/RL3 with DEPTH=8; monitors pop expected beats whenever a beat is handed out.
module tb_eth_10g_mac_st_timing_adapter_rl;
    import eth_10g_st_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- instance A: IN_RL=2, DEPTH=8 ----------------
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    eth_10g_mac_st_timing_adapter_rl_if #(.DATA_W(16)) a_if ();
    logic                      a_rst, a_ovf, a_clr;
    logic [clog2_p1(8)-1:0]    a_fill;
    exp_t                      a_q[$];
    int                        a_cyc = 0;
    int                        a_pops = 0;
    int                        a_first_pop = -1;
    int                        a_last_pop = -1;

    eth_10g_mac_st_timing_adapter_rl #(.DATA_W(16), .IN_RL(2), .DEPTH(8)) u_a (
        .clk(clk), .reset(a_rst), .st(a_if), .fill_level(a_fill), .overflow(a_ovf), .clr_ovf(a_clr)
    );

    always @(posedge clk) a_cyc <= a_cyc + 1;

    initial begin : a_mon
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (a_if.out_valid && a_if.out_ready) begin
                check("a_sb_nonempty", int'(a_q.size() != 0), 1);
                if (a_q.size() != 0) begin
                    e = a_q.pop_front();
                    check("a_data", a_if.out_data, e.data);
                    check("a_latency", a_cyc + 1 - e.cyc, 1);
                    if (a_first_pop < 0) a_first_pop = a_cyc + 1;
                    a_last_pop = a_cyc + 1;
                    a_pops++;
                end
            end
        end
    end

    initial begin : a_stim
        logic [2:0] hist;
        int sent;
        a_rst = 1'b1; a_clr = 1'b0;
        a_if.in_valid = 1'b1; a_if.in_data = 16'hBEEF; a_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_rst_in_ready", a_if.in_ready, 0);
            check("a_rst_out_valid", a_if.out_valid, 0);
            check("a_rst_out_data", a_if.out_data, 0);
            check("a_rst_fill", a_fill, 0);
            check("a_rst_ovf", a_ovf, 0);
        end
        a_rst = 1'b0; a_if.in_valid = 1'b0;
        @(negedge clk);
        check("a_rel_in_ready", a_if.in_ready, 1);
        check("a_rel_fill", a_fill, 0);
        check("a_rel_out_valid", a_if.out_valid, 0);

        a_if.out_ready = 1'b1;
        hist = '0; sent = 0;
        for (int i = 0; i < 200 && sent < 64; i++) begin
            hist = {hist[1:0], a_if.in_ready};
            if (hist[2]) begin
                a_if.in_valid = 1'b1;
                a_if.in_data  = 16'(sent + 1);
                a_q.push_back('{data: 16'(sent + 1), cyc: a_cyc + 1});
                sent++;
            end else begin
                a_if.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        a_if.in_valid = 1'b0;
        for (int i = 0; i < 20 && a_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("a_sent", sent, 64);
        check("a_pops", a_pops, 64);
        check("a_pop_span", a_last_pop - a_first_pop, 63);
        check("a_sb_drained", a_q.size(), 0);
        check("a_ovf_stream", a_ovf, 0);
        done_cnt++;
    end

    // ---------------- instance B: IN_RL=2, DEPTH=4 ----------------
    eth_10g_mac_st_timing_adapter_rl_if #(.DATA_W(16)) b_if ();
    logic                      b_rst, b_ovf, b_clr;
    logic [clog2_p1(4)-1:0]    b_fill;
    logic [15:0]               b_q[$];

    eth_10g_mac_st_timing_adapter_rl #(.DATA_W(16), .IN_RL(2), .DEPTH(4)) u_b (
        .clk(clk), .reset(b_rst), .st(b_if), .fill_level(b_fill), .overflow(b_ovf), .clr_ovf(b_clr)
    );

    initial begin : b_mon
        forever begin
            @(negedge clk); #2;
            if (b_if.out_valid && b_if.out_ready) begin
                check("b_sb_nonempty", int'(b_q.size() != 0), 1);
                if (b_q.size() != 0) check("b_data", b_if.out_data, b_q.pop_front());
            end
        end
    end

    initial begin : b_stim
        logic [2:0] hist;
        int sent;
        b_rst = 1'b1; b_clr = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
        @(negedge clk);

        hist = '0; sent = 0;
        repeat (16) begin
            hist = {hist[1:0], b_if.in_ready};
            if (hist[2]) begin
                b_if.in_valid = 1'b1;
                b_if.in_data  = 16'(sent + 1);
                b_q.push_back(16'(sent + 1));
                sent++;
            end else begin
                b_if.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b_grants", sent, 4);
        check("b_full_fill", b_fill, 4);
        check("b_full_in_ready", b_if.in_ready, 0);
        check("b_full_ovf", b_ovf, 0);

        b_if.in_valid = 1'b1; b_if.in_data = 16'hDEAD;
        @(negedge clk);
        check("b_drop_ovf", b_ovf, 1);
        check("b_drop_fill", b_fill, 4);
        b_clr = 1'b1;
        @(negedge clk);
        check("b_clr_drop_ovf", b_ovf, 1);
        b_if.in_valid = 1'b0;
        @(negedge clk);
        check("b_clr_ovf", b_ovf, 0);
        b_clr = 1'b0;

        b_if.in_valid = 1'b1; b_if.in_data = 16'h0005; b_if.out_ready = 1'b1;
        b_q.push_back(16'h0005);
        @(negedge clk);
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        check("b_pushpop_fill", b_fill, 4);
        check("b_pushpop_ovf", b_ovf, 0);
        check("b_pushpop_head", b_if.out_data, 16'h0002);

        b_if.out_ready = 1'b1;
        for (int i = 0; i < 10 && b_q.size() != 0; i++) @(negedge clk);
        check("b_drain_sb", b_q.size(), 0);
        check("b_drain_fill", b_fill, 0);
        check("b_drain_out_valid", b_if.out_valid, 0);
        b_if.out_ready = 1'b0;
        done_cnt++;
    end

    // ---------------- random out_ready: IN_RL in {0,1,3}, DEPTH=8 ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int RL = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        eth_10g_mac_st_timing_adapter_rl_if #(.DATA_W(16)) r_if ();
        logic                   r_rst, r_ovf, r_clr;
        logic [clog2_p1(8)-1:0] r_fill;
        logic [15:0]            r_q[$];

        eth_10g_mac_st_timing_adapter_rl #(.DATA_W(16), .IN_RL(RL), .DEPTH(8)) u_r (
            .clk(clk), .reset(r_rst), .st(r_if), .fill_level(r_fill), .overflow(r_ovf), .clr_ovf(r_clr)
        );

        initial begin : r_mon
            forever begin
                @(negedge clk); #2;
                if (r_if.out_valid && r_if.out_ready) begin
                    check($sformatf("rl%0d_sb_nonempty", RL), int'(r_q.size() != 0), 1);
                    if (r_q.size() != 0) check($sformatf("rl%0d_data", RL), r_if.out_data, r_q.pop_front());
                end
            end
        end

        initial begin : r_stim
            logic [3:0] hist;
            int sent;
            r_rst = 1'b1; r_clr = 1'b0;
            r_if.in_valid = 1'b0; r_if.in_data = '0; r_if.out_ready = 1'b0;
            repeat (2) @(negedge clk);
            r_rst = 1'b0;
            @(negedge clk);

            hist = '0; sent = 0;
            for (int i = 0; i < 600 && sent < 120; i++) begin
                r_if.out_ready = 1'($urandom_range(0, 1));
                hist = {hist[2:0], r_if.in_ready};
                if (hist[RL]) begin
                    r_if.in_valid = 1'b1;
                    r_if.in_data  = 16'(sent + 1);
                    r_q.push_back(16'(sent + 1));
                    sent++;
                end else begin
                    r_if.in_valid = 1'b0;
                end
                @(negedge clk);
            end
            r_if.in_valid = 1'b0;
            for (int i = 0; i < 300 && r_q.size() != 0; i++) begin
                r_if.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            r_if.out_ready = 1'b0;
            check($sformatf("rl%0d_sent", RL), sent, 120);
            check($sformatf("rl%0d_no_loss", RL), r_q.size(), 0);
            check($sformatf("rl%0d_ovf", RL), r_ovf, 0);

            hist = '0;
            repeat (6) begin
                hist = {hist[2:0], r_if.in_ready};
                if (hist[RL]) begin
                    r_if.in_valid = 1'b1;
                    r_if.in_data  = 16'(16'h0100 + sent);
                    r_q.push_back(16'(16'h0100 + sent));
                    sent++;
                end else begin
                    r_if.in_valid = 1'b0;
                end
                @(negedge clk);
            end
            check($sformatf("rl%0d_prefill", RL), int'(r_fill != 0), 1);
            r_rst = 1'b1; r_if.in_valid = 1'b0;
            r_q.delete();
            @(negedge clk);
            check($sformatf("rl%0d_rst_fill", RL), r_fill, 0);
            check($sformatf("rl%0d_rst_out_valid", RL), r_if.out_valid, 0);
            r_rst = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("rl%0d_post_fill", RL), r_fill, 0);
            check($sformatf("rl%0d_post_ovf", RL), r_ovf, 0);
            done_cnt++;
        end
    end

    initial begin : summary
        int t;
        t = 0;
        while (done_cnt < 5 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("all_done", done_cnt, 5);
        #3;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
